// File: rtl/rtc_alarm_counter.sv
// rtc_alarm_counter: free-running 1 Hz RTC counter with NUM_ALARMS match channels.
// Each channel latches a sticky raw interrupt when the counter is updated onto its
// match value; interrupts are masked onto INTR/INTRCOMB by ALARMEN.
// Optional feature macro: RTC_ALARM_COUNTER_TESTCOUNT_EN enables the TESTCOUNT
// override path; without it TESTCOUNT/RTCTCOUNT are present but ignored.
module rtc_alarm_counter #(
  parameter int unsigned           CNT_WIDTH  = 32,
  parameter int unsigned           NUM_ALARMS = 4,
  parameter logic [CNT_WIDTH-1:0]  RST_VALUE  = 1
) (
  input  logic                  CLK1HZ,
  input  logic                  RTCRST,
  input  logic                  CNTEN,
  input  logic                  LOADEN,
  input  logic [CNT_WIDTH-1:0]  LOADVAL,
  input  logic                  TESTCOUNT,
  input  logic [CNT_WIDTH-1:0]  RTCTCOUNT,
  input  logic [NUM_ALARMS-1:0] MATCHWE,
  input  logic [CNT_WIDTH-1:0]  MATCHVAL,
  input  logic [NUM_ALARMS-1:0] ALARMEN,
  input  logic [NUM_ALARMS-1:0] INTCLR,
  output logic [CNT_WIDTH-1:0]  Count,
  output logic [NUM_ALARMS-1:0] RAWINT,
  output logic [NUM_ALARMS-1:0] INTR,
  output logic                  INTRCOMB,
  output logic                  WRAP
);

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  logic                  test_sel;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  upd;
  logic                  wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0]  match_q [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] rawint_q, rawint_d;

`ifdef RTC_ALARM_COUNTER_TESTCOUNT_EN
  assign test_sel = TESTCOUNT;
`else
  // Test path compiled out: ports kept for pin compatibility only.
  logic unused_testcount;
  assign unused_testcount = ^{TESTCOUNT, RTCTCOUNT};
  assign test_sel = 1'b0;
`endif

  // Counter next value: test override, then load, then increment, else hold.
  always_comb begin
    count_d = count_q;
    upd     = 1'b0;
    wrap_d  = 1'b0;
    if (test_sel) begin
      count_d = RTCTCOUNT;
      upd     = 1'b1;
    end else if (LOADEN) begin
      count_d = LOADVAL;
      upd     = 1'b1;
    end else if (CNTEN) begin
      count_d = count_q + CntOne;
      upd     = 1'b1;
      // Only an increment rollover counts as a wrap, never a load of zero.
      wrap_d  = (count_q == '1);
    end
  end

  // Raw status: set on an update onto the pre-edge match value; set beats clear.
  always_comb begin
    rawint_d = rawint_q & ~INTCLR;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (upd && (count_d == match_q[i])) begin
        rawint_d[i] = 1'b1;
      end
    end
  end

  // Counter, wrap pulse and raw status registers.
  always_ff @(posedge CLK1HZ or posedge RTCRST) begin
    if (RTCRST) begin
      count_q  <= RST_VALUE;
      wrap_q   <= 1'b0;
      rawint_q <= '0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      rawint_q <= rawint_d;
    end
  end

  // Match registers; the compare above sees the old value on a same-edge write.
  always_ff @(posedge CLK1HZ or posedge RTCRST) begin
    if (RTCRST) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        match_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (MATCHWE[i]) begin
          match_q[i] <= MATCHVAL;
        end
      end
    end
  end

  // Outputs: masked interrupts are combinational on the raw status.
  always_comb begin
    Count    = count_q;
    WRAP     = wrap_q;
    RAWINT   = rawint_q;
    INTR     = rawint_q & ALARMEN;
    INTRCOMB = |(rawint_q & ALARMEN);
  end

endmodule

// File: tb/tb_rtc_alarm_counter.sv
// Directed bench for rtc_alarm_counter at default parameters (32-bit, 4 alarms).
module tb_rtc_alarm_counter;

  logic        CLK1HZ = 1'b0;
  logic        RTCRST;
  logic        CNTEN;
  logic        LOADEN;
  logic [31:0] LOADVAL;
  logic        TESTCOUNT;
  logic [31:0] RTCTCOUNT;
  logic [3:0]  MATCHWE;
  logic [31:0] MATCHVAL;
  logic [3:0]  ALARMEN;
  logic [3:0]  INTCLR;
  logic [31:0] Count;
  logic [3:0]  RAWINT;
  logic [3:0]  INTR;
  logic        INTRCOMB;
  logic        WRAP;

  int pass_cnt  = 0;
  int check_cnt = 0;

  rtc_alarm_counter dut (
    .CLK1HZ    (CLK1HZ),
    .RTCRST    (RTCRST),
    .CNTEN     (CNTEN),
    .LOADEN    (LOADEN),
    .LOADVAL   (LOADVAL),
    .TESTCOUNT (TESTCOUNT),
    .RTCTCOUNT (RTCTCOUNT),
    .MATCHWE   (MATCHWE),
    .MATCHVAL  (MATCHVAL),
    .ALARMEN   (ALARMEN),
    .INTCLR    (INTCLR),
    .Count     (Count),
    .RAWINT    (RAWINT),
    .INTR      (INTR),
    .INTRCOMB  (INTRCOMB),
    .WRAP      (WRAP)
  );

  always #5 CLK1HZ = ~CLK1HZ;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge CLK1HZ);
    #1;
  endtask

  initial begin
    RTCRST = 1'b1; CNTEN = 1'b0; LOADEN = 1'b0; LOADVAL = '0;
    TESTCOUNT = 1'b0; RTCTCOUNT = '0; MATCHWE = '0; MATCHVAL = '0;
    ALARMEN = '0; INTCLR = '0;
    #1;
    check("rst_count", Count, 1);
    check("rst_rawint", RAWINT, 0);
    check("rst_wrap", WRAP, 0);
    check("rst_intr", INTR, 0);
    @(posedge CLK1HZ); #2;
    RTCRST = 1'b0;

    // Plain increment from reset value.
    CNTEN = 1'b1;
    step(); check("inc1", Count, 2);
    step(); check("inc2", Count, 3);
    step(); check("inc3", Count, 4);
    check("inc_rawint", RAWINT, 0);
    check("inc_wrap", WRAP, 0);

    // Load near top, increment through all-ones (matches reset value) and wrap.
    CNTEN = 1'b0; LOADEN = 1'b1; LOADVAL = 32'hFFFF_FFFE;
    step(); check("load_fffe", Count, 32'hFFFF_FFFE);
    LOADEN = 1'b0; CNTEN = 1'b1;
    step(); check("inc_ffff", Count, 32'hFFFF_FFFF);
    check("wrap_pre", WRAP, 0);
    check("rawint_allones", RAWINT, 4'hF);
    step(); check("wrap_count", Count, 0);
    check("wrap_pulse", WRAP, 1);
    CNTEN = 1'b0;
    step(); check("wrap_single", WRAP, 0);
    check("hold_count", Count, 0);

    // Loading zero from all-ones must not pulse WRAP.
    LOADEN = 1'b1; LOADVAL = 32'hFFFF_FFFF;
    step();
    LOADVAL = 32'h0;
    step(); check("load0_count", Count, 0);
    check("load0_wrap", WRAP, 0);
    LOADEN = 1'b0; INTCLR = 4'hF;
    step(); check("clr_all", RAWINT, 0);
    INTCLR = '0;

    // Alarm 2 at 0x10, masked first.
    MATCHWE = 4'b0100; MATCHVAL = 32'h10; LOADEN = 1'b1; LOADVAL = 32'h0E;
    step(); check("load_0e", Count, 32'h0E);
    MATCHWE = '0; LOADEN = 1'b0; CNTEN = 1'b1;
    step(); check("inc_0f", Count, 32'h0F);
    check("no_match_0f", RAWINT, 0);
    step(); check("inc_10", Count, 32'h10);
    check("match_raw", RAWINT, 4'b0100);
    check("match_masked", INTR, 0);
    check("match_masked_comb", INTRCOMB, 0);
    CNTEN = 1'b0; ALARMEN = 4'b0100;
    #1;
    check("unmask_intr", INTR, 4'b0100);
    check("unmask_comb", INTRCOMB, 1);
    INTCLR = 4'b0100;
    step(); check("held_no_reset", RAWINT, 0);
    check("held_comb", INTRCOMB, 0);

    // Set wins over clear on the same edge; later clear alone takes effect.
    INTCLR = '0; LOADEN = 1'b1; LOADVAL = 32'h10;
    step(); check("load_match", RAWINT, 4'b0100);
    INTCLR = 4'b0100;
    step(); check("set_over_clr", RAWINT, 4'b0100);
    LOADEN = 1'b0;
    step(); check("clr_later", RAWINT, 0);
    INTCLR = '0;

    // Same-edge match write compares against the old match value.
    LOADEN = 1'b1; LOADVAL = 32'h10; MATCHWE = 4'b0100; MATCHVAL = 32'h20;
    step(); check("old_match", RAWINT, 4'b0100);
    MATCHWE = '0; LOADEN = 1'b0; INTCLR = 4'b0100;
    step();
    INTCLR = '0; LOADEN = 1'b1; LOADVAL = 32'h20;
    step(); check("new_match", RAWINT, 4'b0100);
    LOADEN = 1'b0; INTCLR = 4'b0100;
    step(); INTCLR = '0;

    // Multi-channel match write.
    MATCHWE = 4'b0011; MATCHVAL = 32'h55;
    step(); MATCHWE = '0;
    check("multi_pre", RAWINT, 0);
    LOADEN = 1'b1; LOADVAL = 32'h55;
    step(); check("multi_match", RAWINT, 4'b0011);
    check("multi_intr", INTR, 0);

    // Test-count override versus load.
    TESTCOUNT = 1'b1; RTCTCOUNT = 32'h1234; LOADVAL = 32'h5678;
    step();
`ifdef RTC_ALARM_COUNTER_TESTCOUNT_EN
    check("testcount", Count, 32'h1234);
`else
    check("testcount", Count, 32'h5678);
`endif
    TESTCOUNT = 1'b0;

    // Asynchronous reset mid-count with pending status.
    LOADVAL = 32'h40;
    step(); LOADEN = 1'b0;
    check("pre_rst_count", Count, 32'h40);
    check("pre_rst_raw", RAWINT, 4'b0011);
    #2;
    RTCRST = 1'b1;
    #1;
    check("async_count", Count, 1);
    check("async_raw", RAWINT, 0);
    check("async_wrap", WRAP, 0);
    @(posedge CLK1HZ); #2;
    RTCRST = 1'b0;

    // Match registers return to all-ones after reset.
    LOADEN = 1'b1; LOADVAL = 32'hFFFF_FFFF; ALARMEN = 4'b1000;
    step(); LOADEN = 1'b0;
    check("match_rst_raw", RAWINT, 4'hF);
    check("match_rst_intr", INTR, 4'b1000);
    check("match_rst_comb", INTRCOMB, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_counter.md
RTC_ALARM_COUNTER -- requirements
Module: rtc_alarm_counter

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32: counter and match register width, legal range 8..64.
REQ-002 The block SHALL have parameter NUM_ALARMS, default 4: number of independent alarm channels, legal range 1..8.
REQ-003 The block SHALL have parameter RST_VALUE, default 1: counter value loaded on reset, CNT_WIDTH bits.
REQ-004 The block SHALL have port CLK1HZ, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RTCRST, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port CNTEN, input, 1 bit: count enable.
REQ-007 The block SHALL have ports LOADEN (input, 1 bit) and LOADVAL (input, CNT_WIDTH bits): synchronous counter load.
REQ-008 The block SHALL have ports TESTCOUNT (input, 1 bit) and RTCTCOUNT (input, CNT_WIDTH bits): test-count override.
REQ-009 The block SHALL have ports MATCHWE (input, NUM_ALARMS bits, per-channel write enables) and MATCHVAL (input, CNT_WIDTH bits): shared match write data.
REQ-010 The block SHALL have ports ALARMEN (input, NUM_ALARMS bits, interrupt masks) and INTCLR (input, NUM_ALARMS bits, raw interrupt clears).
REQ-011 The block SHALL have port Count, output, CNT_WIDTH bits: registered counter value.
REQ-012 The block SHALL have ports RAWINT (output, NUM_ALARMS bits, sticky raw status), INTR (output, NUM_ALARMS bits, equal to RAWINT AND ALARMEN, combinational) and INTRCOMB (output, 1 bit, OR of INTR).
REQ-013 The block SHALL have port WRAP, output, 1 bit: registered single-cycle rollover pulse.

Function
REQ-014 Counter next-value priority SHALL be: TESTCOUNT=1 loads RTCTCOUNT; else LOADEN=1 loads LOADVAL; else CNTEN=1 loads Count+1; else Count holds.
REQ-015 Increment SHALL be modulo 2^CNT_WIDTH: all-ones wraps to zero with no saturation.
REQ-016 WRAP SHALL be 1 in exactly the cycle following an edge at which Count went from all-ones to zero by increment; a load or test write of zero SHALL NOT assert WRAP.
REQ-017 The counter SHALL have one-edge latency: a qualifying input sampled at edge N is visible on Count after edge N.
REQ-018 MATCHWE[i]=1 SHALL write MATCHVAL into Match[i] at the edge; several bits set SHALL write all selected channels.
REQ-019 RAWINT[i] SHALL set at an edge where Count is updated (test, load or increment) and the new value equals Match[i] as held before that edge; a held Count SHALL NOT re-set it.
REQ-020 RAWINT[i] SHALL remain set until INTCLR[i]=1 is sampled; a set and a clear at the same edge SHALL leave RAWINT[i]=1.
REQ-021 A Match[i] write and a match event at the same edge SHALL compare against the old Match[i].
REQ-022 ALARMEN SHALL gate only INTR/INTRCOMB; RAWINT SHALL set regardless of ALARMEN.

Reset
REQ-023 While RTCRST=1, independent of CLK1HZ: Count=RST_VALUE, every Match[i]=all-ones, RAWINT=0, WRAP=0; INTR and INTRCOMB therefore 0.
REQ-024 Deassertion of RTCRST SHALL take effect at the first rising edge of CLK1HZ with RTCRST low; reset mid-count SHALL abandon the count and lose pending status.

Configuration
REQ-025 With macro RTC_ALARM_COUNTER_TESTCOUNT_EN defined, the TESTCOUNT path SHALL operate as in REQ-014.
REQ-026 Without RTC_ALARM_COUNTER_TESTCOUNT_EN, TESTCOUNT and RTCTCOUNT SHALL remain as ports but be ignored, and priority SHALL reduce to LOADEN, CNTEN, hold.

Verification
REQ-027 Reset then CNTEN=1 for 3 edges (CNT_WIDTH=32, RST_VALUE=1) -> Count 1,2,3,4; RAWINT=0; WRAP=0.
REQ-028 LOADVAL=0xFFFFFFFE with LOADEN=1 for 1 edge, then CNTEN=1 -> Count 0xFFFFFFFF, 0x00000000; WRAP=1 for exactly that one cycle.
REQ-029 Match[2]=0x10, Count=0x0E, CNTEN=1, ALARMEN=0 -> RAWINT[2]=1 after the edge to 0x10 and INTR=0; then ALARMEN[2]=1 -> INTR[2]=1 and INTRCOMB=1.
REQ-030 RAWINT[2]=1 with INTCLR[2]=1 held across a new match edge -> RAWINT[2] stays 1; INTCLR[2]=1 on a later edge with no match -> RAWINT[2]=0.
REQ-031 TESTCOUNT=1, RTCTCOUNT=0x1234, LOADEN=1, LOADVAL=0x5678 -> Count=0x1234 with the macro defined, Count=0x5678 with it undefined.
REQ-032 RTCRST asserted between clock edges while Count=0x40 and RAWINT=0x3 -> Count=1 and RAWINT=0 immediately, with no clock edge required.
